// File: rtl/wb_riot.sv
// Wishbone RIOT (6532-style): up to two I/O ports with DDRs, a prescaled interval
// timer that underflows into divide-by-1 countdown, a PA7 edge flag and a combined IRQ.
module wb_riot #(
    parameter int NUM_PORTS   = 2,
    parameter int PORT_W      = 8,
    parameter int TIMER_W     = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        stb_i,
    input  logic                        we_i,
    input  logic [6:0]                  adr_i,
    input  logic [7:0]                  dat_i,
    output logic                        ack_o,
    output logic [7:0]                  dat_o,
    input  logic                        tick_i,
    input  logic [NUM_PORTS*PORT_W-1:0] port_i,
    output logic [NUM_PORTS*PORT_W-1:0] port_o,
    output logic [NUM_PORTS*PORT_W-1:0] port_oe,
    output logic                        irq_o
);
    logic [NUM_PORTS-1:0][PORT_W-1:0] r_sync [SYNC_STAGES];
    logic [NUM_PORTS-1:0][PORT_W-1:0] r_port_o, r_oe, w_pins, w_pval;
    logic                r_ack, r_pa7_d, r_edge_pol, r_edge_ie, r_edge_flag;
    logic                r_tim_flag, r_tim_ie;
    logic [7:0]          r_dat, w_rdata;
    logic [TIMER_W-1:0]  r_intim;
    logic [1:0]          r_div;
    logic [9:0]          r_presc, w_lim;
    logic                w_acc, w_wr, w_rd, w_rd_intim, w_rd_flags, w_wr_ectl, w_wr_tload;
    logic                w_edge, w_dec;

    assign w_acc      = stb_i & ~r_ack;
    assign w_wr       = w_acc & we_i;
    assign w_rd       = w_acc & ~we_i;
    assign w_rd_intim = w_rd & ((adr_i == 7'h04) || (adr_i == 7'h0C));
    assign w_rd_flags = w_rd & ((adr_i == 7'h05) || (adr_i == 7'h0D));
    assign w_wr_ectl  = w_wr & (adr_i[6:5] == 2'b00) & ~adr_i[4] & adr_i[2];
    assign w_wr_tload = w_wr & (adr_i[6:5] == 2'b00) & adr_i[4] & adr_i[2];

    assign w_pins = r_sync[SYNC_STAGES-1];
    assign w_edge = r_edge_pol ? (w_pins[0][PORT_W-1] & ~r_pa7_d)
                               : (~w_pins[0][PORT_W-1] & r_pa7_d);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) r_sync[s] <= '0;
            r_pa7_d <= 1'b0;
        end else begin
            r_sync[0] <= port_i;
            for (int s = 1; s < SYNC_STAGES; s++) r_sync[s] <= r_sync[s-1];
            r_pa7_d <= w_pins[0][PORT_W-1];
        end
    end

    // Output bits show the driven value, input bits show the synchronised pin.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++)
            w_pval[k] = (r_port_o[k] & r_oe[k]) | (w_pins[k] & ~r_oe[k]);
    end

    always_comb begin
        w_rdata = 8'h00;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (adr_i == 7'(2*k))     w_rdata = 8'(w_pval[k]);
            if (adr_i == 7'(2*k + 1)) w_rdata = 8'(r_oe[k]);
        end
        if ((adr_i == 7'h04) || (adr_i == 7'h0C)) w_rdata = 8'(r_intim);
        if ((adr_i == 7'h05) || (adr_i == 7'h0D)) w_rdata = {r_tim_flag, r_edge_flag, 6'b0};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ack <= 1'b0;
            r_dat <= 8'h00;
        end else begin
            r_ack <= w_acc;
            if (w_rd) r_dat <= w_rdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_port_o <= '0;
            r_oe     <= '0;
        end else if (w_wr) begin
            for (int k = 0; k < NUM_PORTS; k++) begin
                if (adr_i == 7'(2*k))     r_port_o[k] <= dat_i[PORT_W-1:0];
                if (adr_i == 7'(2*k + 1)) r_oe[k]     <= dat_i[PORT_W-1:0];
            end
        end
    end

    always_comb begin
        case (r_div)
            2'd0:    w_lim = 10'd0;
            2'd1:    w_lim = 10'd7;
            2'd2:    w_lim = 10'd63;
            default: w_lim = 10'd1023;
        endcase
    end
    assign w_dec = tick_i & (r_presc == w_lim);

    // Underflow drops to divide-by-1 until software reloads the timer.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_intim    <= '0;
            r_div      <= 2'd0;
            r_presc    <= '0;
            r_tim_flag <= 1'b0;
            r_tim_ie   <= 1'b0;
        end else if (w_wr_tload) begin
            r_intim    <= dat_i[TIMER_W-1:0];
            r_div      <= adr_i[1:0];
            r_tim_ie   <= adr_i[3];
            r_presc    <= '0;
            r_tim_flag <= 1'b0;
        end else begin
            if (tick_i) r_presc <= w_dec ? 10'd0 : r_presc + 10'd1;
            if (w_rd_intim) r_tim_flag <= 1'b0;
            if (w_dec) begin
                if (r_intim == '0) begin
                    r_intim    <= '1;
                    r_tim_flag <= 1'b1;
                    r_div      <= 2'd0;
                end else begin
                    r_intim <= r_intim - TIMER_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_edge_pol  <= 1'b0;
            r_edge_ie   <= 1'b0;
            r_edge_flag <= 1'b0;
        end else begin
            if (w_wr_ectl) begin
                r_edge_pol <= adr_i[0];
                r_edge_ie  <= adr_i[1];
            end
            if (w_rd_flags) r_edge_flag <= 1'b0;
            if (w_edge)     r_edge_flag <= 1'b1;
        end
    end

    assign ack_o   = r_ack;
    assign dat_o   = r_dat;
    assign port_o  = r_port_o;
    assign port_oe = r_oe;
    assign irq_o   = (r_tim_flag & r_tim_ie) | (r_edge_flag & r_edge_ie);
endmodule

// File: tb/tb_wb_riot.sv
// Directed bench for wb_riot: a register-access vector table plus hand-timed
// sequences for the timer, edge flag, strobe handshake and reset.
module tb_wb_riot;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        stb = 1'b0, we = 1'b0, tick = 1'b0;
    logic [6:0]  adr = '0;
    logic [7:0]  dat = '0;
    logic [15:0] pin_i = '0;
    logic        ack0, irq0, ack1, irq1;
    logic [7:0]  dat0, dat1, rd0, rd1;
    logic [15:0] po0, oe0;
    logic [3:0]  po1, oe1;
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    wb_riot dut0 (
        .clk_i(clk), .rst_ni(rst_n), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat),
        .ack_o(ack0), .dat_o(dat0), .tick_i(tick), .port_i(pin_i),
        .port_o(po0), .port_oe(oe0), .irq_o(irq0)
    );

    wb_riot #(.NUM_PORTS(1), .PORT_W(4)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat),
        .ack_o(ack1), .dat_o(dat1), .tick_i(tick), .port_i(pin_i[3:0]),
        .port_o(po1), .port_oe(oe1), .irq_o(irq1)
    );

    typedef struct {
        logic       we;
        logic [6:0] adr;
        logic [7:0] dat;
        logic [7:0] exp0;
        logic [7:0] exp1;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Entered at a negedge: accept on the next posedge, returns two negedges later.
    task automatic bus(input logic w, input logic [6:0] a, input logic [7:0] d);
        stb = 1'b1; we = w; adr = a; dat = d;
        @(negedge clk);
        rd0 = dat0; rd1 = dat1;
        chk("ack", ack0, 1'b1);
        stb = 1'b0; we = 1'b0;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic rdchk(input string nm, input logic [6:0] a, input logic [7:0] exp);
        bus(1'b0, a, 8'h00);
        chk(nm, rd0, exp);
    endtask

    initial begin
        tbl[0]  = '{1'b1, 7'h01, 8'hF0, 8'h00, 8'h00};
        tbl[1]  = '{1'b1, 7'h00, 8'hA5, 8'h00, 8'h00};
        tbl[2]  = '{1'b1, 7'h03, 8'h0F, 8'h00, 8'h00};
        tbl[3]  = '{1'b1, 7'h02, 8'h35, 8'h00, 8'h00};
        tbl[4]  = '{1'b0, 7'h00, 8'h00, 8'hAC, 8'h0C};
        tbl[5]  = '{1'b0, 7'h01, 8'h00, 8'hF0, 8'h00};
        tbl[6]  = '{1'b0, 7'h02, 8'h00, 8'hC5, 8'h00};
        tbl[7]  = '{1'b0, 7'h03, 8'h00, 8'h0F, 8'h00};
        tbl[8]  = '{1'b0, 7'h04, 8'h00, 8'h00, 8'h00};
        tbl[9]  = '{1'b0, 7'h05, 8'h00, 8'h00, 8'h00};
        tbl[10] = '{1'b0, 7'h30, 8'h00, 8'h00, 8'h00};
        tbl[11] = '{1'b0, 7'h0D, 8'h00, 8'h00, 8'h00};

        pin_i = 16'hC03C;
        idle(3);
        chk("rst ack", ack0, 1'b0);
        chk("rst dat", dat0, 8'h00);
        chk("rst port_o", po0, 16'h0000);
        chk("rst port_oe", oe0, 16'h0000);
        chk("rst irq", irq0, 1'b0);
        rst_n = 1'b1;
        idle(1);

        // Register map
        for (int i = 0; i < 12; i++) begin
            bus(tbl[i].we, tbl[i].adr, tbl[i].dat);
            if (!tbl[i].we) begin
                chk($sformatf("rd0 %0h", tbl[i].adr), rd0, tbl[i].exp0);
                chk($sformatf("rd1 %0h", tbl[i].adr), rd1, tbl[i].exp1);
            end
        end
        chk("port_o", po0, 16'h35A5);
        chk("port_oe", oe0, 16'h0FF0);
        chk("port_o np1", po1, 4'h5);
        chk("port_oe np1", oe1, 4'h0);

        // Divide-by-8 countdown then underflow into divide-by-1
        tick = 1'b1;
        bus(1'b1, 7'h15, 8'h03);
        rdchk("intim 3", 7'h04, 8'h03);
        idle(5);
        rdchk("intim 2", 7'h04, 8'h02);
        idle(6);
        rdchk("intim 1", 7'h04, 8'h01);
        idle(6);
        rdchk("intim 0", 7'h04, 8'h00);
        idle(5);
        rdchk("intim at underflow", 7'h04, 8'h00);
        rdchk("flags after underflow", 7'h05, 8'h80);
        rdchk("intim div1", 7'h04, 8'hFC);
        chk("irq no ie", irq0, 1'b0);

        // Immediate underflow with interrupt enabled, then reload
        bus(1'b1, 7'h1C, 8'h00);
        chk("irq tim", irq0, 1'b1);
        rdchk("intim wrap", 7'h04, 8'hFF);
        chk("irq cleared", irq0, 1'b0);
        tick = 1'b0;
        bus(1'b1, 7'h14, 8'h10);
        rdchk("intim reload", 7'h04, 8'h10);
        rdchk("flags reload", 7'h05, 8'h00);
        idle(10);
        rdchk("intim frozen", 7'h04, 8'h10);

        // PA7 rising edge
        bus(1'b1, 7'h07, 8'h00);
        chk("irq pre edge", irq0, 1'b0);
        pin_i = 16'hC0BC;
        idle(2);
        chk("edge 2cyc", irq0, 1'b0);
        idle(1);
        chk("edge 3cyc", irq0, 1'b1);
        rdchk("flags edge", 7'h05, 8'h40);
        rdchk("flags edge clr", 7'h05, 8'h00);
        chk("irq edge clr", irq0, 1'b0);
        pin_i = 16'hC03C;
        idle(5);
        rdchk("flags falling", 7'h05, 8'h00);

        // Strobe held four cycles
        stb = 1'b1; we = 1'b1; adr = 7'h00; dat = 8'h11;
        chk("hold ack0", ack0, 1'b0);
        @(negedge clk); chk("hold ack1", ack0, 1'b1); dat = 8'h22;
        @(negedge clk); chk("hold ack2", ack0, 1'b0); dat = 8'h33;
        @(negedge clk); chk("hold ack3", ack0, 1'b1); dat = 8'h44;
        @(negedge clk); chk("hold ack4", ack0, 1'b0);
        stb = 1'b0; we = 1'b0;
        chk("hold writes", po0[7:0], 8'h33);
        idle(1);

        // Asynchronous reset mid-countdown
        tick = 1'b1;
        bus(1'b1, 7'h1C, 8'h00);
        chk("irq before rst", irq0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async irq", irq0, 1'b0);
        chk("async port_o", po0, 16'h0000);
        chk("async port_oe", oe0, 16'h0000);
        chk("async ack", ack0, 1'b0);
        chk("async dat", dat0, 8'h00);
        @(negedge clk);
        tick = 1'b0;
        rst_n = 1'b1;
        rdchk("intim post rst", 7'h04, 8'h00);
        rdchk("flags post rst", 7'h05, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/wb_riot.md
Name: wb_riot

Overview:
- Parametrised Wishbone RIOT (6532-style) peripheral for the Atari 2600 core; successor to the fixed single-port PIA.
- Provides up to two bidirectional I/O ports with data-direction registers and a prescaled interval timer with real underflow behaviour.
- Adds a timer interrupt flag, a PA7 edge-detect flag, and a combined IRQ output.
- Sits on the CPU Wishbone bus alongside the TIA; port pins connect to joysticks and console switches.

Parameters:
- NUM_PORTS, 2, number of I/O ports, legal range 1..2. Port 0 = A, port 1 = B.
- PORT_W, 8, width of each port, legal range 1..8. Reads zero-extend to 8 bits.
- TIMER_W, 8, INTIM width, legal range 1..8. Reads zero-extend.
- SYNC_STAGES, 2, depth of the input synchroniser on port pins, minimum 1.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- stb_i  in  1  Wishbone strobe.
- we_i  in  1  write enable.
- adr_i  in  7  register address.
- dat_i  in  8  write data.
- ack_o  out  1  Wishbone acknowledge, registered.
- dat_o  out  8  read data, registered.
- tick_i  in  1  timer clock enable (CPU-cycle ready); the prescaler advances only when high.
- port_i  in  NUM_PORTS*PORT_W  pin inputs; port k occupies bits [k*PORT_W +: PORT_W].
- port_o  out  NUM_PORTS*PORT_W  output data register.
- port_oe  out  NUM_PORTS*PORT_W  per-bit output enable; 1 = drive.
- irq_o  out  1  (tim_flag & tim_ie) | (edge_flag & edge_ie).

Behaviour:
- Reset is asynchronous, active-low. All of the following clear to 0: ack_o, dat_o, port_o, port_oe, intim, prescale counter, tim_flag, tim_ie, edge_flag, edge_ie, edge_pol, synchroniser flops. Divider resets to 1.
- Handshake: ack_o <= stb_i & ~ack_o. This gives exactly one ack per strobe, one cycle after strobe assertion. Register side effects occur only in the accept cycle (stb_i & ~ack_o).
- Read map, returned on dat_o with ack:
  - 0x00 + 2k: port k value, bitwise oe ? port_o : synchronised port_i.
  - 0x01 + 2k: DDR k (port_oe).
  - 0x04 or 0x0C: INTIM. The read clears tim_flag.
  - 0x05 or 0x0D: flags; bit7 = tim_flag, bit6 = edge_flag. The read clears edge_flag.
  - Addresses for ports k >= NUM_PORTS and any unmapped address return 0x00.
- Write map:
  - 0x00 + 2k: port_o k.
  - 0x01 + 2k: DDR k.
  - 0x04..0x07 (adr[4]=0, adr[2]=1): edge_pol <= adr[0] (1 = rising, 0 = falling); edge_ie <= adr[1].
  - 0x14..0x17 and 0x1C..0x1F: timer load.
  - Writes to undefined addresses are ignored but still acked.
- Timer load:
  - intim <= dat_i[TIMER_W-1:0].
  - Divider <= 1, 8, 64, 1024 for adr[1:0] = 0..3.
  - tim_ie <= adr[3].
  - Prescale counter <= 0; tim_flag <= 0.
- Timer run:
  - On tick_i the prescale counter increments.
  - When counter == divider-1 it returns to 0 and a decrement occurs.
  - Decrement with intim != 0: intim <= intim-1.
  - Decrement with intim == 0: intim wraps to all-ones, tim_flag <= 1, divider <= 1. The timer then counts down once per tick until the next load.
  - Reading INTIM does not restore the divider.
- Edge detect:
  - Monitors the synchronised bit PORT_W-1 of port 0. The detector uses the last sync stage versus its delayed copy.
  - A matching edge sets edge_flag, regardless of DDR.
- Priority within one cycle:
  - Timer load beats decrement and underflow.
  - Underflow flag-set beats INTIM-read clear, so the flag stays 1. The read returns the pre-update intim.
  - An edge beats a flags-read clear.
  - Port input latency is SYNC_STAGES cycles to the read path and SYNC_STAGES+1 cycles to edge_flag.
- Reset asserted mid-operation immediately clears all state. The first access after release sees reset values.

Test Plan:
- Write 0x01=0xF0, then 0x00=0xA5, port_i A=0x3C. Read 0x00 -> 0xAC; port_oe A=0xF0, port_o A=0xA5.
- Write 0x15 data 0x03 with tick_i held high: INTIM decrements every 8 ticks, 3->2->1->0. Eight ticks after reaching 0 it reads 0xFF and bit7 of 0x05 = 1. Next tick gives 0xFE, i.e. divide-by-1. irq_o stays 0.
- Write 0x1C data 0x00: after 1 tick tim_flag=1 and irq_o=1. Read 0x04 -> irq_o drops next cycle. Write 0x14 data 0x10: flag stays clear and INTIM restarts at 0x10.
- Write 0x07 (rising, ie), drive port_i A bit7 0->1: edge_flag set 3 cycles later, irq_o=1. Read 0x05 -> 0x40, then flag clear. A falling edge does not set the flag.
- Hold stb_i high for 4 cycles with a write: ack_o toggles 0,1,0,1 and exactly two writes are performed. Drop tick_i: prescaler freezes and intim holds.
- Assert rst_ni low mid-countdown with irq_o=1: all outputs go 0 asynchronously, and INTIM reads 0x00 after release. With NUM_PORTS=1, read 0x02 -> 0x00.
